// File: rtl/reg_bank_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bank_reader_if
//  Description : Beat stream carrying register-bank words from the reader to
//                its consumer (valid/ready handshake with word index and a
//                last-beat marker).
//  Revision    : 1.0  initial release
// ============================================================================
interface reg_bank_reader_if #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 4
);
  logic [WIDTH-1:0] out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  // Reader side: offers beats, observes acceptance.
  modport master (
    output out_data,
    output out_idx,
    output out_valid,
    output out_last,
    input  out_ready
  );

  // Consumer side: observes beats, grants acceptance.
  modport slave (
    input  out_data,
    input  out_idx,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/reg_bank_reader.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bank_reader
//  Description : Captures a coherent snapshot of the whole register bank on a
//                start request and streams the words out one per beat.
//                Optional build macro REG_BANK_READER_CHECKSUM_EN appends a
//                final beat carrying the XOR of all captured words.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_bank_reader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH + 1)
) (
  input  wire logic                   clk,
  input  wire logic                   clr,
  input  wire logic                   start,
  input  wire logic [WIDTH*DEPTH-1:0] bank_in,
  output logic                        busy,
  output logic                        done,
  reg_bank_reader_if.master           out_if
);

  localparam int               SEL_W    = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
`ifdef REG_BANK_READER_CHECKSUM_EN
    S_CHECK  = 2'd2,
`endif
    S_DONE   = 2'd3
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] snap_q [DEPTH];
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] data_q;
  logic [IDX_W-1:0] oidx_q;
  logic             valid_q;
  logic             last_q;

  assign idx_d = idx_q + IDX_W'(1);

`ifdef REG_BANK_READER_CHECKSUM_EN
  logic [WIDTH-1:0] csum_q;
  logic [WIDTH-1:0] csum_d;

  // XOR of the words being captured, so the checksum matches the snapshot.
  always_comb begin
    csum_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      csum_d = csum_d ^ bank_in[k*WIDTH +: WIDTH];
    end
  end
`endif

  // Control FSM: capture on start, advance one word per accepted beat.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      for (int k = 0; k < DEPTH; k++) begin
        snap_q[k] <= '0;
      end
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      oidx_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
`ifdef REG_BANK_READER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            for (int k = 0; k < DEPTH; k++) begin
              snap_q[k] <= bank_in[k*WIDTH +: WIDTH];
            end
`ifdef REG_BANK_READER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
            // First beat is loaded straight from the capture so it is
            // offered on the very next cycle.
            idx_q   <= '0;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
            data_q  <= bank_in[0 +: WIDTH];
            oidx_q  <= '0;
            last_q  <= 1'b0;
            state_q <= S_STREAM;
          end
        end

        S_STREAM: begin
          if (out_if.out_ready) begin
            if (idx_q == LAST_IDX) begin
`ifdef REG_BANK_READER_CHECKSUM_EN
              idx_q   <= idx_d;
              data_q  <= csum_q;
              oidx_q  <= idx_d;
              last_q  <= 1'b1;
              state_q <= S_CHECK;
`else
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
`endif
            end else begin
              idx_q  <= idx_d;
              data_q <= snap_q[idx_d[SEL_W-1:0]];
              oidx_q <= idx_d;
`ifdef REG_BANK_READER_CHECKSUM_EN
              last_q <= 1'b0;
`else
              last_q <= (idx_d == LAST_IDX);
`endif
            end
          end
        end

`ifdef REG_BANK_READER_CHECKSUM_EN
        S_CHECK: begin
          if (out_if.out_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
`endif

        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_idx   = oidx_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_last  = last_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_bank_reader
//  Description : Scoreboard bench for reg_bank_reader: expected beats are
//                queued when a start is accepted and popped as the DUT
//                offers them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reg_bank_reader;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int IDX_W = $clog2(DEPTH + 1);
  localparam int BUDGET = 200;

  logic                   clk = 1'b0;
  logic                   clr;
  logic                   start;
  logic [WIDTH*DEPTH-1:0] bank_in;
  logic                   busy;
  logic                   done;

  reg_bank_reader_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

  reg_bank_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk     (clk),
    .clr     (clr),
    .start   (start),
    .bank_in (bank_in),
    .busy    (busy),
    .done    (done),
    .out_if  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  beat_t exp_q[$];
  int    phase = 0;      // reference model: 0 idle, 1 streaming, 2 done cycle
  int    checks = 0;
  int    fails = 0;
  bit    mon_en = 1'b0;
  int    ready_mode = 0; // 0 full, 1 alternate, 2 random, 3 alternate + stall at idx 3
  int    bank_mode = 0;  // 0 hold, 1 all ones after capture, 2 random every cycle
  int    stall_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected stream for one snapshot, derived from the word list alone.
  task automatic push_stream(input logic [WIDTH*DEPTH-1:0] b);
    beat_t            bt;
    logic [WIDTH-1:0] x;
    x = '0;
    for (int k = 0; k < DEPTH; k++) begin
      bt.idx  = IDX_W'(k);
      bt.data = b[k*WIDTH +: WIDTH];
`ifdef REG_BANK_READER_CHECKSUM_EN
      bt.last = 1'b0;
`else
      bt.last = (k == DEPTH - 1);
`endif
      x = x ^ bt.data;
      exp_q.push_back(bt);
    end
`ifdef REG_BANK_READER_CHECKSUM_EN
    bt.idx  = IDX_W'(DEPTH);
    bt.data = x;
    bt.last = 1'b1;
    exp_q.push_back(bt);
`endif
  endtask

  // Monitor: compare the current cycle, then advance the model across the next edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", 64'(busy), 64'(phase != 0));
      chk("done", 64'(done), 64'(phase == 2));
      chk("out_valid", 64'(bus.out_valid), 64'(phase == 1));
      if (phase == 1 && bus.out_valid && exp_q.size() > 0) begin
        chk("out_data", 64'(bus.out_data), 64'(exp_q[0].data));
        chk("out_idx", 64'(bus.out_idx), 64'(exp_q[0].idx));
        chk("out_last", 64'(bus.out_last), 64'(exp_q[0].last));
      end
    end
    if (clr) begin
      exp_q.delete();
      phase = 0;
    end else begin
      case (phase)
        0: if (start) begin
             push_stream(bank_in);
             phase = 1;
           end
        1: if (bus.out_ready && exp_q.size() > 0) begin
             void'(exp_q.pop_front());
             if (exp_q.size() == 0) phase = 2;
           end
        default: phase = 0;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH*DEPTH-1:0] mk_bank(input int kind);
    logic [WIDTH*DEPTH-1:0] b;
    for (int k = 0; k < DEPTH; k++) begin
      case (kind)
        0:       b[k*WIDTH +: WIDTH] = 32'hA000_0000 + 32'(k);
        1:       b[k*WIDTH +: WIDTH] = 32'(1) << k;
        default: b[k*WIDTH +: WIDTH] = $urandom;
      endcase
    end
    return b;
  endfunction

  task automatic drive_cycle_inputs();
    case (ready_mode)
      0: bus.out_ready = 1'b1;
      1: bus.out_ready = ~bus.out_ready;
      2: bus.out_ready = 1'($urandom);
      default: begin
        if (bus.out_valid && bus.out_idx == IDX_W'(3) && stall_cnt < 5) begin
          bus.out_ready = 1'b0;
          stall_cnt++;
        end else begin
          bus.out_ready = ~bus.out_ready;
        end
      end
    endcase
    case (bank_mode)
      0: ;
      1: bank_in = '1;
      default: bank_in = mk_bank(2);
    endcase
  endtask

  task automatic recover();
    clr = 1'b1;
    start = 1'b0;
    step();
    clr = 1'b0;
    step();
  endtask

  // One start request followed by the stream it produces.
  task automatic run_stream(input logic [WIDTH*DEPTH-1:0] b, input int rmode,
                            input int bmode, input bit hold);
    int n;
    ready_mode = rmode;
    bank_mode  = bmode;
    stall_cnt  = 0;
    bank_in    = b;
    bus.out_ready = (rmode == 2) ? 1'($urandom) : 1'b1;
    start = 1'b1;
    step();
    if (!hold) start = 1'b0;
    n = 0;
    while (phase != 0 && n < BUDGET) begin
      drive_cycle_inputs();
      step();
      n++;
    end
    start = 1'b0;
    if (n >= BUDGET) begin
      checks++;
      fails++;
      $display("FAIL stream_timeout: got phase %0d expected idle within %0d cycles", phase, BUDGET);
      recover();
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1;
    start = 1'b1;
    bank_in = mk_bank(0);
    bus.out_ready = 1'b1;
    repeat (2) step();
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_valid", 64'(bus.out_valid), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_data", 64'(bus.out_data), 64'(0));
    chk("reset_idx", 64'(bus.out_idx), 64'(0));
    clr = 1'b0;
    start = 1'b0;
    mon_en = 1'b1;
    step();

    // Full rate, then snapshot isolation, then backpressure.
    run_stream(mk_bank(0), 0, 0, 1'b0);
    run_stream(mk_bank(0), 0, 1, 1'b0);
    run_stream(mk_bank(0), 3, 0, 1'b0);

    // Abort at idx 4 with start held high through the clear.
    bank_in = mk_bank(2);
    bus.out_ready = 1'b1;
    ready_mode = 0;
    bank_mode = 0;
    start = 1'b1;
    step();
    for (int n = 0; n < 20 && !(bus.out_valid && bus.out_idx == IDX_W'(4)); n++) step();
    chk("abort_reached_idx4", 64'(bus.out_idx), 64'(4));
    clr = 1'b1;
    step();
    clr = 1'b0;
    start = 1'b0;
    repeat (3) step();

    // Start held through stream and DONE; dropped at IDLE, so no restart.
    run_stream(mk_bank(2), 0, 2, 1'b1);
    run_stream(mk_bank(1), 0, 0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      run_stream(mk_bank(2), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                 1'($urandom));
    end

    repeat (3) step();
    chk("final_queue_empty", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
`default_nettype wire
